// File: rtl/text_gpu_ctrl.sv
// Text-mode VGA controller: scrolled text RAM, font lookup, blinking cursor.
// Display state advances on pix_en; control registers are shadowed once per frame.
module text_gpu_ctrl #(
   parameter int COLS   = 80,
   parameter int ROWS   = 30,
   parameter int FONT_H = 16,
   parameter int H_FP   = 16,
   parameter int H_SY   = 96,
   parameter int H_BP   = 48,
   parameter int V_FP   = 10,
   parameter int V_SY   = 2,
   parameter int V_BP   = 33,
   parameter int AW     = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          reg_wr,
   input  logic [1:0]    reg_addr,
   input  logic [7:0]    reg_data,
   output logic          h_sync,
   output logic          v_sync,
   output logic          pixel,
   output logic          vblank
);
   localparam int H_ACT = COLS * 8;
   localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
   localparam int V_ACT = ROWS * FONT_H;
   localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
   localparam int XW    = $clog2(H_TOT);
   localparam int YW    = $clog2(V_TOT);
   localparam int LB    = $clog2(FONT_H);
   localparam int NCELL = COLS * ROWS;
   localparam int DEPTH = 2 ** AW;

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          vblank_q;
   logic [7:0]    scroll_q, ccol_q, crow_q;
   logic [1:0]    ctrl_q;
   logic [7:0]    scroll_s_q, ccol_s_q, crow_s_q;
   logic [1:0]    ctrl_s_q;
   logic [5:0]    frame_q;

   logic [7:0]    ram_q [DEPTH];
   logic [7:0]    code_q;
   logic [2:0]    xb1_q;
   logic [LB-1:0] ln1_q;
   logic          act1_q, hs1_q, vs1_q, hit1_q;
   logic          hs2_q, vs2_q, pix2_q;

   logic          act0, hs0, vs0, hit0, vb_tick;
   logic [AW-1:0] rd_addr;
   logic [LB-1:0] ln0;
   logic [6:0]    gidx;
   logic [7:0]    grow;
   logic          pix_d;

   // Built-in glyph set: index 0 blank, every other glyph topped by 0x18.
   function automatic logic [7:0] font(input logic [6:0] idx, input logic [LB-1:0] ln);
      logic [7:0] r;
      if (idx == 7'd0) r = 8'h00;
      else if (ln == '0) r = 8'h18;
      else r = 8'(int'(idx) * 7 + int'(ln) * 13);
      return r;
   endfunction

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pix_en) begin
         if (x_q == XW'(H_TOT - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(V_TOT - 1)) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_comb begin
      int col, srow, trow;
      col     = int'(x_q) / 8;
      srow    = int'(y_q) / FONT_H;
      trow    = srow + int'(scroll_s_q);
      if (trow >= ROWS) trow = trow - ROWS;
      rd_addr = AW'(trow * COLS + col);
      ln0     = y_q[LB-1:0];
      act0    = (int'(x_q) < H_ACT) && (int'(y_q) < V_ACT);
      hs0     = !((int'(x_q) >= H_ACT + H_FP) && (int'(x_q) < H_ACT + H_FP + H_SY));
      vs0     = !((int'(y_q) >= V_ACT + V_FP) && (int'(y_q) < V_ACT + V_FP + V_SY));
      // Cursor cell is matched in screen coordinates, independent of scroll.
      hit0    = ctrl_s_q[0] && frame_q[5] && (col == int'(ccol_s_q))
                && (srow == int'(crow_s_q)) && (int'(ln0) >= FONT_H - 2);
      vb_tick = pix_en && (x_q == XW'(H_TOT - 1)) && (y_q == YW'(V_ACT - 1));
   end

   always_comb begin
      gidx  = (code_q >= 8'd32 && code_q <= 8'd127) ? 7'(code_q - 8'd32) : 7'd0;
      grow  = font(gidx, ln1_q);
      pix_d = act1_q & (grow[3'd7 - xb1_q] ^ ctrl_s_q[1] ^ hit1_q);
   end

   // Read-first dual-port text RAM; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && int'(wr_addr) < NCELL) ram_q[wr_addr] <= wr_data;
      if (pix_en) code_q <= ram_q[rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         vblank_q <= 1'b0;
         xb1_q    <= '0;
         ln1_q    <= '0;
         act1_q   <= 1'b0;
         hs1_q    <= 1'b1;
         vs1_q    <= 1'b1;
         hit1_q   <= 1'b0;
         hs2_q    <= 1'b1;
         vs2_q    <= 1'b1;
         pix2_q   <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         vblank_q <= vb_tick;
         if (pix_en) begin
            xb1_q  <= x_q[2:0];
            ln1_q  <= ln0;
            act1_q <= act0;
            hs1_q  <= hs0;
            vs1_q  <= vs0;
            hit1_q <= hit0;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            pix2_q <= pix_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scroll_q   <= '0;
         ccol_q     <= '0;
         crow_q     <= '0;
         ctrl_q     <= '0;
         scroll_s_q <= '0;
         ccol_s_q   <= '0;
         crow_s_q   <= '0;
         ctrl_s_q   <= '0;
         frame_q    <= '0;
      end else begin
         if (vblank_q) begin
            scroll_s_q <= scroll_q;
            ccol_s_q   <= ccol_q;
            crow_s_q   <= crow_q;
            ctrl_s_q   <= ctrl_q;
            frame_q    <= frame_q + 1'b1;
         end
         if (reg_wr) begin
            unique case (reg_addr)
               2'd0: if (int'(reg_data) < ROWS) scroll_q <= reg_data;
               2'd1: if (int'(reg_data) < COLS) ccol_q <= reg_data;
               2'd2: if (int'(reg_data) < ROWS) crow_q <= reg_data;
               2'd3: ctrl_q <= reg_data[1:0];
            endcase
         end
      end
   end

   assign h_sync = hs2_q;
   assign v_sync = vs2_q;
   assign pixel  = pix2_q;
   assign vblank = vblank_q;
endmodule

// File: tb/tb_text_gpu_ctrl.sv
// Randomized scoreboard bench for text_gpu_ctrl on a small screen geometry.
// A position/frame based reference model predicts sync, pixel and vblank.
module tb_text_gpu_ctrl;
   localparam int COLS = 4, ROWS = 3, FONT_H = 4;
   localparam int H_FP = 2, H_SY = 3, H_BP = 2;
   localparam int V_FP = 1, V_SY = 2, V_BP = 1;
   localparam int AW = 4;
   localparam int H_ACT = COLS * 8;
   localparam int HT = H_ACT + H_FP + H_SY + H_BP;
   localparam int V_ACT = ROWS * FONT_H;
   localparam int VT = V_ACT + V_FP + V_SY + V_BP;
   localparam int NCELL = COLS * ROWS;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst, pix_en, wr_en, reg_wr;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data, reg_data;
   logic [1:0]    reg_addr;
   logic          h_sync, v_sync, pixel, vblank;

   text_gpu_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .FONT_H(FONT_H),
      .H_FP(H_FP), .H_SY(H_SY), .H_BP(H_BP),
      .V_FP(V_FP), .V_SY(V_SY), .V_BP(V_BP), .AW(AW)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
      .h_sync(h_sync), .v_sync(v_sync), .pixel(pixel), .vblank(vblank)
   );

   always #5 clk = ~clk;

   int         mram [NCELL];
   int         live [4];
   int         shad [4];
   int         font_tb [96][FONT_H];
   int         frames, t;
   bit         exp_vb, ticked, in_rst;
   logic [2:0] q [$];
   logic [2:0] cur_exp;
   int         passed, total;

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [2:0] expect_at(int tt);
      int x, y, col, srow, ln, trow, code, gi;
      bit hs, vs, px, gb, hit, blink;
      x  = tt % HT;
      y  = (tt / HT) % VT;
      hs = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SY);
      vs = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SY);
      px = 1'b0;
      if (x < H_ACT && y < V_ACT) begin
         col   = x / 8;
         srow  = y / FONT_H;
         ln    = y % FONT_H;
         trow  = (srow + shad[0]) % ROWS;
         code  = mram[trow * COLS + col];
         gi    = (code >= 32 && code <= 127) ? code - 32 : 0;
         gb    = ((font_tb[gi][ln] >> (7 - x % 8)) & 1) != 0;
         blink = ((frames / 32) % 2) == 1;
         hit   = (shad[3] & 1) != 0 && blink && col == shad[1]
                 && srow == shad[2] && ln >= FONT_H - 2;
         px    = gb ^ ((shad[3] >> 1) & 1) ^ hit;
      end
      return {hs, vs, px};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         live[i] = 0;
         shad[i] = 0;
      end
      frames  = 0;
      t       = 0;
      exp_vb  = 1'b0;
      ticked  = 1'b0;
      q.delete();
      q.push_back(3'b110);
      cur_exp = 3'b110;
   endtask

   task automatic idle_inputs();
      pix_en = 1'b0; wr_en = 1'b0; reg_wr = 1'b0;
      wr_addr = '0; wr_data = '0; reg_addr = '0; reg_data = '0;
   endtask

   task automatic step();
      int a;
      @(posedge clk);
      if (exp_vb) begin
         shad = live;
         frames++;
      end
      exp_vb = pix_en && (t % HT) == HT - 1 && ((t / HT) % VT) == V_ACT - 1;
      ticked = pix_en;
      if (pix_en) begin
         q.push_back(expect_at(t));
         t++;
      end
      if (wr_en && int'(wr_addr) < NCELL) mram[wr_addr] = int'(wr_data);
      if (reg_wr) begin
         a = int'(reg_addr);
         if (a == 0 && int'(reg_data) < ROWS) live[0] = int'(reg_data);
         if (a == 1 && int'(reg_data) < COLS) live[1] = int'(reg_data);
         if (a == 2 && int'(reg_data) < ROWS) live[2] = int'(reg_data);
         if (a == 3) live[3] = int'(reg_data) & 3;
      end
      #1;
   endtask

   task automatic do_reset();
      in_rst = 1'b1;
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("rst_h_sync", h_sync, 1);
      chk("rst_v_sync", v_sync, 1);
      chk("rst_pixel", pixel, 0);
      chk("rst_vblank", vblank, 0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      in_rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!in_rst) begin
         if (ticked) begin
            if (q.size() == 0) chk("queue_empty", 0, 1);
            else cur_exp = q.pop_front();
         end
         chk("h_sync", h_sync, cur_exp[2]);
         chk("v_sync", v_sync, cur_exp[1]);
         chk("pixel", pixel, cur_exp[0]);
         chk("vblank", vblank, exp_vb);
      end
   end

   task automatic rand_inputs();
      pix_en   = ($urandom_range(0, 15) != 0);
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(32, 127));
      reg_wr   = ($urandom_range(0, 299) == 0);
      reg_addr = 2'($urandom_range(0, 3));
      reg_data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 5));
   endtask

   initial begin
      passed = 0;
      total  = 0;
      for (int g = 0; g < 96; g++)
         for (int l = 0; l < FONT_H; l++)
            font_tb[g][l] = (g == 0) ? 0 : (l == 0) ? 8'h18 : (g * 7 + l * 13) & 255;
      for (int i = 0; i < NCELL; i++) mram[i] = 0;
      do_reset();

      for (int a = 0; a < NCELL; a++) begin
         wr_en   = 1'b1;
         wr_addr = AW'(a);
         wr_data = (a == 0) ? 8'h41 : (a == 1) ? 8'h07 : 8'($urandom_range(0, 255));
         step();
      end
      wr_en = 1'b0;
      reg_wr = 1'b1; reg_addr = 2'd3; reg_data = 8'd1; step();
      reg_addr = 2'd1; reg_data = 8'd2; step();
      reg_addr = 2'd2; reg_data = 8'd1; step();
      reg_addr = 2'd0; reg_data = 8'(ROWS); step();
      reg_wr = 1'b0;

      for (int n = 0; n < 50000; n++) begin
         if (n == 2000) begin
            idle_inputs();
            pix_en = 1'b1;
            repeat (5) step();
            do_reset();
         end else if (n == 20017) begin
            idle_inputs();
            repeat (100) step();
         end
         rand_inputs();
         step();
      end
      idle_inputs();
      repeat (3) step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
